// File: rtl/pipe_pkg.sv
// Shared types and constants for the MIPS pipeline front-end.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    MDU  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC   = 32'h0000_0180;
  localparam logic [31:0] NOP       = 32'h0000_0000;

endpackage

// File: rtl/pc_stall_counter.sv
// Loadable 8-bit down-counter timing the multiply/divide stall window.
module pc_stall_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero,
  output logic       o_last
);

  logic [7:0] r_cnt;

  assign o_zero = (r_cnt == 8'd0);
  assign o_last = (r_cnt == 8'd1);

  // Load takes priority over decrement; the count saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && !o_zero) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: arbitrates redirects, stalls and flushes for the fetch stage.
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC  = pipe_pkg::RESET_VEC,
  parameter logic [31:0] EXC_VEC    = pipe_pkg::EXC_VEC,
  parameter int unsigned MDU_CYCLES = 32  // valid range 1..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        load_use,
  input  logic        mdu_start,
  input  logic        exc_req,
  input  logic [31:0] exc_pc,
  input  logic        halt_req,
  output logic [31:0] npc,
  output logic        wpc,
  output logic        wir,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic [31:0] epc,
  output logic        busy,
  output logic        halted
);

  import pipe_pkg::*;

  localparam logic [7:0] MDU_LOAD  = 8'(MDU_CYCLES - 1);
  localparam bit         MDU_MULTI = (MDU_CYCLES > 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_epc;
  logic        w_epc_we;
  logic        w_cnt_load;
  logic [7:0]  w_cnt_load_val;
  logic        w_cnt_dec;
  logic        w_cnt_zero;
  logic        w_cnt_last;

  // The start cycle is the first stall cycle, so the MDU state lasts
  // MDU_CYCLES-1 cycles and is left as the count steps down to zero.
  pc_stall_counter u_stall_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero),
    .o_last     (w_cnt_last)
  );

  // Same-cycle redirect/stall/flush decisions and next-state selection.
  always_comb begin
    npc            = pc;
    wpc            = 1'b0;
    wir            = 1'b0;
    flush_ifid     = 1'b0;
    flush_idex     = 1'b0;
    busy           = 1'b0;
    halted         = 1'b0;
    w_next_state   = r_state;
    w_epc_we       = 1'b0;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = '0;
    w_cnt_dec      = 1'b0;
    if (rst) begin
      npc        = RESET_VEC;
      wpc        = 1'b1;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (exc_req) begin
            npc        = EXC_VEC;
            wpc        = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            w_epc_we   = 1'b1;
          end else if (branch_taken) begin
            npc        = branch_target;
            wpc        = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end else if (mdu_start) begin
            flush_idex     = 1'b1;
            w_cnt_load     = 1'b1;
            w_cnt_load_val = MDU_LOAD;
            if (MDU_MULTI) begin
              w_next_state = MDU;
            end
          end else if (halt_req) begin
            flush_idex   = 1'b1;
            w_next_state = HALT;
          end else if (jump) begin
            npc        = jump_target;
            wpc        = 1'b1;
            flush_ifid = 1'b1;
          end else if (load_use) begin
            flush_idex = 1'b1;
          end else begin
            npc = pc + 32'd4;
            wpc = 1'b1;
            wir = 1'b1;
          end
        end
        MDU: begin
          busy = 1'b1;
          if (exc_req) begin
            npc            = EXC_VEC;
            wpc            = 1'b1;
            flush_ifid     = 1'b1;
            flush_idex     = 1'b1;
            w_epc_we       = 1'b1;
            w_next_state   = RUN;
            w_cnt_load     = 1'b1;
            w_cnt_load_val = '0;
          end else begin
            flush_idex = 1'b1;
            w_cnt_dec  = 1'b1;
            if (w_cnt_last || w_cnt_zero) begin
              w_next_state = RUN;
            end
          end
        end
        HALT: begin
          halted     = 1'b1;
          flush_idex = 1'b1;
        end
        default: begin
          w_next_state = RUN;
        end
      endcase
    end
  end

  // State and exception-PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_epc   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_epc_we) begin
        r_epc <= exc_pc;
      end
    end
  end

  assign epc = r_epc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table, directed corner
// sequences and randomized stimulus against a behavioural model.
module tb_pc_sequencer;

  localparam int unsigned MDU_N   = 4;
  localparam logic [31:0] EXC_A   = 32'h0000_0180;
  localparam logic [31:0] RESET_A = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] npc;
    logic        wpc;
    logic        wir;
    logic        fi;
    logic        fx;
    logic [31:0] epc;
    logic        busy;
    logic        halted;
  } out_t;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] pc;
    logic        jump;
    logic [31:0] jt;
    logic        br;
    logic [31:0] bt;
    logic        lu;
    logic        mdu;
    out_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, jump, branch_taken, load_use, mdu_start, exc_req, halt_req;
  logic [31:0] pc, jump_target, branch_target, exc_pc;
  logic [31:0] npc, epc;
  logic        wpc, wir, flush_ifid, flush_idex, busy, halted;

  int errors = 0;
  int checks = 0;

  // Model state: remaining MDU-state cycles, halt flag, exception PC.
  int          m_stall;
  bit          m_halted;
  logic [31:0] m_epc;

  out_t s_last;
  vec_t vecs[9];

  pc_sequencer #(
    .RESET_VEC  (RESET_A),
    .EXC_VEC    (EXC_A),
    .MDU_CYCLES (MDU_N)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .load_use      (load_use),
    .mdu_start     (mdu_start),
    .exc_req       (exc_req),
    .exc_pc        (exc_pc),
    .halt_req      (halt_req),
    .npc           (npc),
    .wpc           (wpc),
    .wir           (wir),
    .flush_ifid    (flush_ifid),
    .flush_idex    (flush_idex),
    .epc           (epc),
    .busy          (busy),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic out_t mk(logic [31:0] n, logic w, logic i, logic f1, logic f2,
                              logic [31:0] e, logic b, logic h);
    out_t o;
    o.npc = n; o.wpc = w; o.wir = i; o.fi = f1; o.fx = f2;
    o.epc = e; o.busy = b; o.halted = h;
    return o;
  endfunction

  // Expected outputs for the current inputs, from the priority rules.
  function automatic out_t model_out();
    out_t o;
    o = mk(pc, 1'b0, 1'b0, 1'b0, 1'b0, m_epc, 1'b0, 1'b0);
    if (rst) begin
      o.npc = RESET_A; o.wpc = 1'b1; o.fi = 1'b1; o.fx = 1'b1;
    end else if (m_halted) begin
      o.halted = 1'b1; o.fx = 1'b1;
    end else begin
      o.busy = (m_stall > 0);
      if (exc_req) begin
        o.npc = EXC_A; o.wpc = 1'b1; o.fi = 1'b1; o.fx = 1'b1;
      end else if (m_stall > 0) begin
        o.fx = 1'b1;
      end else if (branch_taken) begin
        o.npc = branch_target; o.wpc = 1'b1; o.fi = 1'b1; o.fx = 1'b1;
      end else if (mdu_start || halt_req || (load_use && !jump)) begin
        o.fx = 1'b1;
      end else if (jump) begin
        o.npc = jump_target; o.wpc = 1'b1; o.fi = 1'b1;
      end else begin
        o.npc = pc + 32'd4; o.wpc = 1'b1; o.wir = 1'b1;
      end
    end
    return o;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_stall = 0; m_halted = 1'b0; m_epc = '0;
    end else if (m_halted) begin
      m_halted = 1'b1;
    end else if (exc_req) begin
      m_stall = 0; m_epc = exc_pc;
    end else if (m_stall > 0) begin
      m_stall = m_stall - 1;
    end else if (branch_taken) begin
      m_stall = 0;
    end else if (mdu_start) begin
      m_stall = int'(MDU_N) - 1;
    end else if (halt_req) begin
      m_halted = 1'b1;
    end
  endtask

  task automatic check_out(string name, out_t exp);
    out_t act;
    act = {npc, wpc, wir, flush_ifid, flush_idex, epc, busy, halted};
    s_last = act;
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got npc=%h wpc=%b wir=%b fi=%b fx=%b epc=%h busy=%b halted=%b, expected npc=%h wpc=%b wir=%b fi=%b fx=%b epc=%h busy=%b halted=%b",
               name, act.npc, act.wpc, act.wir, act.fi, act.fx, act.epc, act.busy, act.halted,
               exp.npc, exp.wpc, exp.wir, exp.fi, exp.fx, exp.epc, exp.busy, exp.halted);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: compare mid-cycle, then let the edge advance DUT and model.
  task automatic run_cycle(string name, bit use_exp, out_t exp);
    @(negedge clk);
    if (use_exp) check_out(name, exp);
    else         check_out(name, model_out());
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; jump = 1'b0; branch_taken = 1'b0; load_use = 1'b0;
    mdu_start = 1'b0; exc_req = 1'b0; halt_req = 1'b0;
    jump_target = '0; branch_target = '0; exc_pc = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    run_cycle("reset_pulse", 1'b0, '0);
    rst = 1'b0;
  endtask

  initial begin
    int stall_n, busy_n;
    m_stall = 0; m_halted = 1'b0; m_epc = '0;
    idle();
    pc = 32'h0;

    vecs[0] = '{"reset_out",    1'b1, 32'h0000_1234, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0,
                mk(32'h0, 1, 0, 1, 1, 32'h0, 0, 0)};
    vecs[1] = '{"seq_pc0",      1'b0, 32'h0000_0000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0,
                mk(32'h4, 1, 1, 0, 0, 32'h0, 0, 0)};
    vecs[2] = '{"seq_wrap",     1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0,
                mk(32'h0, 1, 1, 0, 0, 32'h0, 0, 0)};
    vecs[3] = '{"br_over_jump", 1'b0, 32'h0000_0100, 1'b1, 32'h80, 1'b1, 32'h40, 1'b0, 1'b0,
                mk(32'h40, 1, 0, 1, 1, 32'h0, 0, 0)};
    vecs[4] = '{"jump",         1'b0, 32'h0000_0100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0,
                mk(32'h80, 1, 0, 1, 0, 32'h0, 0, 0)};
    vecs[5] = '{"load_use",     1'b0, 32'h0000_0020, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0,
                mk(32'h20, 0, 0, 0, 1, 32'h0, 0, 0)};
    vecs[6] = '{"jump_over_lu", 1'b0, 32'h0000_0100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b0,
                mk(32'h80, 1, 0, 1, 0, 32'h0, 0, 0)};
    vecs[7] = '{"br_over_mdu",  1'b0, 32'h0000_0200, 1'b0, 32'h0, 1'b1, 32'h60, 1'b0, 1'b1,
                mk(32'h60, 1, 0, 1, 1, 32'h0, 0, 0)};
    vecs[8] = '{"seq_after_br", 1'b0, 32'h0000_0060, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0,
                mk(32'h64, 1, 1, 0, 0, 32'h0, 0, 0)};

    do_reset();
    foreach (vecs[k]) begin
      idle();
      rst = vecs[k].rst; pc = vecs[k].pc;
      jump = vecs[k].jump; jump_target = vecs[k].jt;
      branch_taken = vecs[k].br; branch_target = vecs[k].bt;
      load_use = vecs[k].lu; mdu_start = vecs[k].mdu;
      run_cycle(vecs[k].name, 1'b1, vecs[k].exp);
    end

    // load_use held for two cycles, then sequential fetch resumes.
    idle(); pc = 32'h20; load_use = 1'b1;
    run_cycle("lu_cycle1", 1'b1, mk(32'h20, 0, 0, 0, 1, 32'h0, 0, 0));
    run_cycle("lu_cycle2", 1'b1, mk(32'h20, 0, 0, 0, 1, 32'h0, 0, 0));
    load_use = 1'b0;
    run_cycle("lu_release", 1'b1, mk(32'h24, 1, 1, 0, 0, 32'h0, 0, 0));

    // MDU stall window: count cycles with wpc low and busy high.
    idle(); pc = 32'h10; mdu_start = 1'b1;
    stall_n = 0; busy_n = 0;
    for (int i = 0; i < 12; i++) begin
      run_cycle("mdu_window", 1'b0, '0);
      mdu_start = 1'b0;
      if (s_last.wpc) break;
      stall_n++;
      if (s_last.busy) busy_n++;
    end
    check_int("mdu_stall_cycles", stall_n, 4);
    check_int("mdu_busy_cycles", busy_n, 3);
    check_int("mdu_resume_npc", int'(s_last.npc), 32'h14);

    // Exception during the MDU stall aborts it.
    idle(); pc = 32'h10; mdu_start = 1'b1;
    run_cycle("exc_mdu_start", 1'b1, mk(32'h10, 0, 0, 0, 1, 32'h0, 0, 0));
    mdu_start = 1'b0;
    run_cycle("exc_mdu_stall", 1'b1, mk(32'h10, 0, 0, 0, 1, 32'h0, 1, 0));
    exc_req = 1'b1; exc_pc = 32'h1C;
    run_cycle("exc_in_mdu", 1'b1, mk(32'h180, 1, 0, 1, 1, 32'h0, 1, 0));
    idle();
    run_cycle("exc_mdu_after", 1'b1, mk(32'h14, 1, 1, 0, 0, 32'h1C, 0, 0));

    // Exception beats a simultaneous mdu_start in RUN.
    exc_req = 1'b1; mdu_start = 1'b1; exc_pc = 32'h44;
    run_cycle("exc_over_mdu", 1'b1, mk(32'h180, 1, 0, 1, 1, 32'h1C, 0, 0));
    idle();
    run_cycle("exc_over_mdu_after", 1'b1, mk(32'h14, 1, 1, 0, 0, 32'h44, 0, 0));

    // HALT is sticky, ignores exceptions, and only reset leaves it.
    pc = 32'h30; halt_req = 1'b1;
    run_cycle("halt_enter", 1'b1, mk(32'h30, 0, 0, 0, 1, 32'h44, 0, 0));
    idle(); exc_req = 1'b1; exc_pc = 32'h99; jump = 1'b1; jump_target = 32'h500;
    for (int i = 0; i < 3; i++)
      run_cycle("halt_hold", 1'b1, mk(32'h30, 0, 0, 0, 1, 32'h44, 0, 1));
    idle(); rst = 1'b1;
    run_cycle("halt_reset", 1'b1, mk(32'h0, 1, 0, 1, 1, 32'h44, 0, 0));
    rst = 1'b0;
    run_cycle("halt_after_reset", 1'b1, mk(32'h34, 1, 1, 0, 0, 32'h0, 0, 0));

    // Reset in the middle of an MDU stall.
    pc = 32'h10; mdu_start = 1'b1;
    run_cycle("rst_mdu_start", 1'b0, '0);
    mdu_start = 1'b0;
    run_cycle("rst_mdu_stall", 1'b0, '0);
    rst = 1'b1;
    run_cycle("rst_mdu_reset", 1'b0, '0);
    rst = 1'b0;
    run_cycle("rst_mdu_after", 1'b1, mk(32'h14, 1, 1, 0, 0, 32'h0, 0, 0));

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(99) < 3);
      pc            = ($urandom_range(9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      jump          = ($urandom_range(99) < 20);
      jump_target   = $urandom & 32'hFFFF_FFFC;
      branch_taken  = ($urandom_range(99) < 12);
      branch_target = $urandom & 32'hFFFF_FFFC;
      load_use      = ($urandom_range(99) < 20);
      mdu_start     = ($urandom_range(99) < 10);
      exc_req       = ($urandom_range(99) < 6);
      exc_pc        = $urandom;
      halt_req      = ($urandom_range(99) < 3);
      run_cycle("random", 1'b0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
